// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs MIPS instruction fields into 32-bit words and streams them into imem; optional running XOR checksum under ENC_CHECKSUM_EN
`timescale 1ns/1ps
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [31:0]       checksum
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);
  state_t state, state_nx;
  logic fin_l;
  logic legal;
  logic [5:0] opc;
  logic [31:0] enc;
  logic [ADDR_W:0] wc_nx;
  // field packing; kinds above SW are illegal
  always_comb begin
    legal = req_kind <= 3'd4;
    opc   = req_kind == 3'd1 ? 6'b001000 :
            req_kind == 3'd2 ? 6'b000100 :
            req_kind == 3'd3 ? 6'b100011 :
            req_kind == 3'd4 ? 6'b101011 : 6'b000000;
    enc   = req_kind == 3'd0 ? {6'b000000, rs, rt, rd, shamt, funct} : {opc, rs, rt, imm};
    wc_nx = word_count + 1'b1;
  end
  // next state and handshake/strobe outputs, all decoded from state
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    state_nx = start ? ACCEPT : IDLE;
      ACCEPT: begin
        req_ready = 1'b1;
        state_nx  = (req_valid && legal) ? WRITE :
                    (!req_valid && (finish || fin_l)) ? DONE : ACCEPT;
      end
      WRITE: begin
        imem_we  = 1'b1;
        state_nx = (wc_nx == DEPTH_W || fin_l || finish) ? DONE : ACCEPT;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state, address/data registers and sticky window status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_addr  <= BASE_W;
      imem_wdata <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      fin_l      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        imem_addr  <= BASE_W;
        word_count <= '0;
        full       <= 1'b0;
        err        <= 1'b0;
        fin_l      <= 1'b0;
      end
      if (state == ACCEPT && req_valid) begin
        fin_l <= fin_l | finish;
        if (legal) imem_wdata <= enc;
        else err <= 1'b1;
      end
      if (state == WRITE) begin
        word_count <= wc_nx;
        imem_addr  <= imem_addr + 1'b1;
        full       <= wc_nx == DEPTH_W;
      end
    end
  end
`ifdef ENC_CHECKSUM_EN
  // running XOR of written words, advancing with word_count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (state == WRITE) checksum <= checksum ^ imem_wdata;
  end
`else
  assign checksum = 32'h0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed bench for two loader instances (DEPTH 64 and 4) against a behavioural model
`timescale 1ns/1ps
module tb_instr_encoder_loader;
  localparam int AW = 6;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, finish = 1'b0, req_valid = 1'b0;
  logic [2:0] req_kind = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0] funct = '0;
  logic [15:0] imm = '0;
  logic [1:0] rdy, we, dn, fl, er;
  logic [1:0][AW-1:0] addr;
  logic [1:0][31:0] wd, cs;
  logic [1:0][AW:0] wc;
  int errors = 0, checks = 0;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .req_valid(req_valid),
    .req_ready(rdy[0]), .req_kind(req_kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .imem_we(we[0]), .imem_addr(addr[0]), .imem_wdata(wd[0]),
    .word_count(wc[0]), .done(dn[0]), .full(fl[0]), .err(er[0]), .checksum(cs[0]));

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .req_valid(req_valid),
    .req_ready(rdy[1]), .req_kind(req_kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .imem_we(we[1]), .imem_addr(addr[1]), .imem_wdata(wd[1]),
    .word_count(wc[1]), .done(dn[1]), .full(fl[1]), .err(er[1]), .checksum(cs[1]));

  always #5 clk = ~clk;

  function automatic int dep(input int k);
    return k == 0 ? 64 : 4;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] k, input logic [4:0] s, t, d, sh,
                                         input logic [5:0] fn, input logic [15:0] im);
    case (k)
      3'd0: return {6'b000000, s, t, d, sh, fn};
      3'd1: return {6'b001000, s, t, im};
      3'd2: return {6'b000100, s, t, im};
      3'd3: return {6'b100011, s, t, im};
      3'd4: return {6'b101011, s, t, im};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: window open / pending write / done pulse, per instance
  logic [1:0] m_win = '0, m_wr = '0, m_fin = '0, m_dn = '0, m_full = '0, m_err = '0;
  logic [AW:0] m_cnt [2] = '{'0, '0};
  logic [AW-1:0] m_addr [2] = '{'0, '0};
  logic [31:0] m_data [2] = '{'0, '0};
  logic [31:0] m_cs [2] = '{'0, '0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_win[k] <= 1'b0; m_wr[k] <= 1'b0; m_fin[k] <= 1'b0; m_dn[k] <= 1'b0;
        m_full[k] <= 1'b0; m_err[k] <= 1'b0; m_cnt[k] <= '0; m_addr[k] <= '0;
        m_data[k] <= '0; m_cs[k] <= '0;
      end else if (m_dn[k]) begin
        m_dn[k] <= 1'b0;
      end else if (m_wr[k]) begin
        m_wr[k] <= 1'b0;
        m_cnt[k] <= m_cnt[k] + 1'b1;
        m_addr[k] <= m_addr[k] + 1'b1;
        m_cs[k] <= m_cs[k] ^ m_data[k];
        if (int'(m_cnt[k]) + 1 == dep(k)) begin
          m_full[k] <= 1'b1;
          m_dn[k] <= 1'b1;
        end else if (m_fin[k] || finish) m_dn[k] <= 1'b1;
        else m_win[k] <= 1'b1;
      end else if (m_win[k]) begin
        if (req_valid) begin
          m_fin[k] <= m_fin[k] | finish;
          if (req_kind <= 3'd4) begin
            m_wr[k] <= 1'b1;
            m_win[k] <= 1'b0;
            m_data[k] <= encode(req_kind, rs, rt, rd, shamt, funct, imm);
          end else m_err[k] <= 1'b1;
        end else if (finish || m_fin[k]) begin
          m_win[k] <= 1'b0;
          m_dn[k] <= 1'b1;
        end
      end else if (start) begin
        m_win[k] <= 1'b1; m_cnt[k] <= '0; m_full[k] <= 1'b0; m_err[k] <= 1'b0;
        m_fin[k] <= 1'b0; m_addr[k] <= '0; m_cs[k] <= '0;
      end
    end
  end

  // every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), rdy[k], m_win[k]);
      chk($sformatf("we%0d", k), we[k], m_wr[k]);
      chk($sformatf("done%0d", k), dn[k], m_dn[k]);
      chk($sformatf("addr%0d", k), addr[k], m_addr[k]);
      chk($sformatf("count%0d", k), wc[k], m_cnt[k]);
      chk($sformatf("full%0d", k), fl[k], m_full[k]);
      chk($sformatf("err%0d", k), er[k], m_err[k]);
`ifdef ENC_CHECKSUM_EN
      chk($sformatf("cksum%0d", k), cs[k], m_cs[k]);
`else
      chk($sformatf("cksum%0d", k), cs[k], 32'h0);
`endif
      if (m_wr[k]) chk($sformatf("wdata%0d", k), wd[k], m_data[k]);
    end
  end

  task automatic open_win;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] s, t, d, sh,
                      input logic [5:0] fn, input logic [15:0] im, input logic f);
    int n;
    req_kind = k; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im;
    req_valid = 1'b1;
    finish = f;
    n = 0;
    while (!rdy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    finish = 1'b0;
  endtask

  task automatic expw(input logic [31:0] word, input logic [AW-1:0] a);
    chk("lit_we", we[0], 1'b1);
    chk("lit_word", wd[0], word);
    chk("lit_addr", addr[0], a);
    chk("model_word", m_data[0], word);
  endtask

  task automatic close;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("lit_done", dn[0], 1'b1);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_we", we[0], 1'b0);
    chk("rst_addr", addr[0], '0);
    chk("rst_count", wc[0], '0);
    chk("rst_ready", rdy[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    // single R-type word
    open_win;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 1'b0);
    expw(32'h00221820, 6'd0);
    close;
    // mixed I-type program
    open_win;
    send(3'd1, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'd5, 1'b0);
    expw(32'h20020005, 6'd0);
    send(3'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'd4, 1'b0);
    expw(32'h8FA80004, 6'd1);
    send(3'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'd8, 1'b0);
    expw(32'hAFA80008, 6'd2);
    send(3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 1'b0);
    expw(32'h1022FFFF, 6'd3);
    close;
    chk("lit_count4", wc[0], 7'd4);
    chk("lit_full4", fl[1], 1'b1);
`ifdef ENC_CHECKSUM_EN
    chk("lit_cksum", cs[0], 32'h1020FFF6);
`else
    chk("lit_cksum", cs[0], 32'h0);
`endif
    // illegal kind then legal request at the same address
    open_win;
    send(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 1'b0);
    chk("ill_we", we[0], 1'b0);
    chk("ill_err", er[0], 1'b1);
    chk("ill_count", wc[0], '0);
    send(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0042, 1'b0);
    expw(32'h20640042, 6'd0);
    close;
    // stream six requests: DEPTH=4 instance fills and closes
    open_win;
    for (int i = 0; i < 6; i++) begin
      send(3'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'(i), 1'b0);
      expw({16'h2001, 16'(i)}, 6'(i));
    end
    close;
    chk("str_count", wc[0], 7'd6);
    chk("str_full", fl[1], 1'b1);
    chk("str_count4", wc[1], 7'd4);
    chk("str_ready4", rdy[1], 1'b0);
    // finish with accepted request, valid held through WRITE
    open_win;
    req_kind = 3'd3; rs = 5'd2; rt = 5'd5; imm = 16'h0010;
    req_valid = 1'b1;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    expw(32'h8C450010, 6'd0);
    @(negedge clk);
    chk("sim_done", dn[0], 1'b1);
    chk("sim_we", we[0], 1'b0);
    chk("sim_count", wc[0], 7'd1);
    req_valid = 1'b0;
    @(negedge clk);
    // reset during WRITE
    open_win;
    send(3'd1, 5'd0, 5'd7, 5'd0, 5'd0, 6'h0, 16'h1234, 1'b0);
    chk("pre_rst_we", we[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", we[0], 1'b0);
    chk("arst_wdata", wd[0], 32'h0);
    chk("arst_count", wc[0], '0);
    chk("arst_addr", addr[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    open_win;
    send(3'd1, 5'd0, 5'd7, 5'd0, 5'd0, 6'h0, 16'h1234, 1'b0);
    expw(32'h20071234, 6'd0);
    chk("post_rst_count", wc[0], '0);
    close;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
